voice_vca_mixer: RTL and testbench
==================================

// Module: voice_vca_mixer
// PURPOSE
//   Shared serial VCA and mixer sitting directly downstream of the envelope stage. On each start it
//   multiplies one voice's waveform sample by that voice's 8-bit envelope level using a shift-add
//   multiplier. It accumulates the products of all voices and, after the last voice, emits one
//   scaled and saturated signed mix sample. Its start/ready pair connects to envelope mult_start/mult_ready.
// PARAMETERS
//   WAVE_W      12  waveform sample width; unsigned offset-binary input
//   ENV_W       8   envelope width; sets multiply iterations
//   NUM_VOICES  3   voices per mix frame; voice NUM_VOICES-1 closes the frame
//   OUT_W       16  signed mix output width
//   MIX_SHIFT   5   arithmetic right shift applied to the accumulator before saturation
// PORTS
//   clk_i        in   1           clock
//   rst_ni       in   1           reset, synchronous, active-low
//   start_i      in   1           start processing voice_idx_i; sampled only in IDLE
//   voice_idx_i  in   2           voice number, sampled with start_i
//   wave_i       in   WAVE_W      waveform sample, offset binary (0x800 = zero)
//   env_i        in   ENV_W       envelope level, unsigned
//   ready_o      out  1           1-cycle pulse: product done (to envelope mult_ready_i)
//   busy_o       out  1           high in every state except IDLE
//   mix_o        out  OUT_W       signed mixed sample; held between updates
//   mix_valid_o  out  1           1-cycle pulse when mix_o updates
// BEHAVIOUR
//   Interface: one clock, clk_i; reset rst_ni is synchronous and active-low. A low rst_ni at a clk_i
//     edge forces IDLE and clears all registers.
//   Reset values: ready_o=0, busy_o=0, mix_o=0, mix_valid_o=0, accumulator=0, FSM=IDLE.
//   Reset mid-operation: the operation is abandoned and no ready_o pulse is produced.
//   FSM states: IDLE -> MULT -> ACC -> DONE -> IDLE.
//   IDLE: if start_i=1, latch voice_idx_i, env_i, and swave = wave_i with the MSB inverted.
//     swave is two's complement. mcand = sign-extend(swave) to P_W = WAVE_W+ENV_W bits. prod=0, cnt=0.
//   MULT: runs ENV_W cycles, LSB-first. Each cycle: if mplier[0]=1, prod += mcand; then mcand <<= 1,
//     mplier >>= 1, cnt++. Leave MULT when cnt = ENV_W-1. Arithmetic is modulo P_W; the exact
//     product always fits in P_W bits.
//   ACC: accumulator width A_W = P_W + clog2(NUM_VOICES), signed.
//     - voice 0: acc = sext(prod). Loading rather than adding makes frames self-aligning.
//     - voices 1..NUM_VOICES-1: acc += sext(prod).
//     - voice_idx >= NUM_VOICES: acc unchanged; no mix update.
//   DONE: ready_o=1 for exactly this cycle.
//     - If the latched voice = NUM_VOICES-1, this cycle also has mix_valid_o=1.
//     - mix_o = sat_OUT_W(acc >>> MIX_SHIFT), using the accumulator value written in ACC.
//     - sat_OUT_W clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   Latency: start_i sampled at edge 0 -> ready_o high in the cycle after edge ENV_W+2
//     (10 cycles when ENV_W=8). Throughput is one voice per ENV_W+3 cycles.
//   start_i outside IDLE is ignored: not queued, no extra ready_o.
//   wave_i, env_i and voice_idx_i may change freely after the start cycle.
//   env_i=0 gives a zero product; the voice still completes with full latency.
//   Nothing is driven combinationally from inputs to outputs.
// TESTING
//   1. v0 wave=0xFFF env=0xFF; v1,v2 env=0 -> ready_o 10 cycles after each start; after v2,
//      mix_o=16312 (521985>>>5) with one mix_valid_o pulse.
//   2. v0 wave=0x000 env=0x80; v1,v2 wave=0x800 -> v0 product=-262144; after v2, mix_o=-8192 (0xE000).
//   3. All 3 voices wave=0xFFF env=0xFF -> mix_o=0x7FFF (saturated).
//      Then all voices wave=0x000 env=0xFF -> mix_o=0x8000.
//   4. Pulse start_i again at cycles 3 and 9 of a voice -> ignored; exactly one ready_o;
//      busy_o high throughout the voice.
//   5. rst_ni low for one cycle during MULT (cycle 4) -> no ready_o/mix_valid_o, mix_o=0, busy_o=0.
//      The next full frame from test 1 yields 16312.
//   6. voice_idx=3, wave=0xFFF env=0xFF -> ready_o pulses; mix_o and accumulator unchanged;
//      no mix_valid_o.

Source files
------------

// File: rtl/voice_vca_mixer.sv
// Shared serial VCA and mixer: shift-add multiplies each voice's sample by its envelope level,
// accumulates one frame of voices and emits a scaled, saturated signed mix sample.
module voice_vca_mixer #(
    parameter int unsigned WAVE_W     = 12,
    parameter int unsigned ENV_W      = 8,
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned MIX_SHIFT  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        voice_idx_i,
    input  logic [WAVE_W-1:0] wave_i,
    input  logic [ENV_W-1:0]  env_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic [OUT_W-1:0]  mix_o,
    output logic              mix_valid_o
);

    localparam int unsigned P_W   = WAVE_W + ENV_W;
    localparam int unsigned A_W   = P_W + $clog2(NUM_VOICES);
    localparam int unsigned CNT_W = (ENV_W > 1) ? $clog2(ENV_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ENV_W - 1);
    localparam logic [1:0]       LAST_VOICE = 2'(NUM_VOICES - 1);

    localparam logic signed [A_W-1:0] SAT_MAX =
        signed'({{(A_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [A_W-1:0] SAT_MIN =
        signed'({{(A_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    typedef enum logic [1:0] {StIdle, StMult, StAcc, StDone} state_t;

    state_t                   r_state;
    logic [1:0]               r_voice;
    logic signed [P_W-1:0]    r_mcand;
    logic [ENV_W-1:0]         r_mplier;
    logic signed [P_W-1:0]    r_prod;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [A_W-1:0]    r_acc;
    logic                     r_ready;
    logic                     r_busy;
    logic [OUT_W-1:0]         r_mix;
    logic                     r_mix_valid;

    logic signed [WAVE_W-1:0] w_swave;
    logic signed [A_W-1:0]    w_prod_ext;
    logic signed [A_W-1:0]    w_shifted;
    logic [OUT_W-1:0]         w_sat;

    // Offset binary to two's complement: flip the MSB.
    assign w_swave    = {~wave_i[WAVE_W-1], wave_i[WAVE_W-2:0]};
    assign w_prod_ext = A_W'(r_prod);
    assign w_shifted  = r_acc >>> MIX_SHIFT;

    always_comb begin
        w_sat = w_shifted[OUT_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_voice     <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
        end else begin
            r_ready     <= 1'b0;
            r_mix_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_voice  <= voice_idx_i;
                        r_mplier <= env_i;
                        r_mcand  <= P_W'(w_swave);
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= StMult;
                    end
                end
                StMult: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand <<< 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= StAcc;
                    end
                end
                StAcc: begin
                    // Voice 0 loads rather than adds so every frame starts clean.
                    if (r_voice == 2'd0) begin
                        r_acc <= w_prod_ext;
                    end else if (32'(r_voice) < NUM_VOICES) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    r_state <= StDone;
                end
                StDone: begin
                    r_ready <= 1'b1;
                    if (r_voice == LAST_VOICE) begin
                        r_mix       <= w_sat;
                        r_mix_valid <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign mix_o       = r_mix;
    assign mix_valid_o = r_mix_valid;

endmodule

// File: tb/tb_voice_vca_mixer.sv
// Scoreboard bench for voice_vca_mixer: the driver queues the expected result of every voice,
// an independent monitor checks each ready_o pulse against the queue head.
module tb_voice_vca_mixer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  voice_idx_i;
    logic [11:0] wave_i;
    logic [7:0]  env_i;
    logic        ready_o;
    logic        busy_o;
    logic [15:0] mix_o;
    logic        mix_valid_o;

    typedef struct {
        int          cyc;
        bit          valid;
        logic [15:0] mix;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_bad = 0;
    logic [15:0] exp_mix_held = '0;

    voice_vca_mixer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .voice_idx_i (voice_idx_i),
        .wave_i      (wave_i),
        .env_i       (env_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .mix_o       (mix_o),
        .mix_valid_o (mix_valid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Monitor: every ready_o pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ready_latency_cycle", cyc, e.cyc);
                    check("mix_valid", int'(mix_valid_o), int'(e.valid));
                    check("mix", int'($signed(mix_o)), int'($signed(e.mix)));
                end
            end else if (mix_valid_o !== 1'b0) begin
                check("mix_valid_without_ready", int'(mix_valid_o), 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge where ready_o is expected, so the next voice
    // can start back-to-back.
    task automatic run_voice(input logic [1:0] idx, input logic [11:0] wave,
                             input logic [7:0] env, input bit last,
                             input logic [15:0] mix_exp, input bit busy_chk);
        int s;
        exp_t e;
        start_i     = 1'b1;
        voice_idx_i = idx;
        wave_i      = wave;
        env_i       = env;
        s = cyc + 1;
        if (last) exp_mix_held = mix_exp;
        e.cyc   = s + 10;
        e.valid = last;
        e.mix   = exp_mix_held;
        exp_q.push_back(e);
        @(negedge clk_i);
        wave_i      = 12'($urandom);
        env_i       = 8'($urandom);
        voice_idx_i = 2'($urandom);
        for (int c = s; c < s + 10; c++) begin
            if (busy_chk) check("busy_during_voice", int'(busy_o), 1);
            start_i = (busy_chk && (c == s + 2 || c == s + 8)) ? 1'b1 : 1'b0;
            @(negedge clk_i);
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        voice_idx_i = '0;
        wave_i      = '0;
        env_i       = '0;
        repeat (2) @(negedge clk_i);
        check("reset_ready", int'(ready_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_mix", int'(mix_o), 0);
        check("reset_mix_valid", int'(mix_valid_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single full-scale voice: 2047*255 = 521985, >>>5 = 16312.
        run_voice(2'd0, 12'hFFF, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd1, 12'hFFF, 8'h00, 1'b0, 16'd0, 1'b0);
        run_voice(2'd2, 12'hFFF, 8'h00, 1'b1, 16'd16312, 1'b0);

        // Spurious starts at cycles 3 and 9 of a busy voice are ignored.
        run_voice(2'd0, 12'hFFF, 8'hFF, 1'b0, 16'd0, 1'b1);
        run_voice(2'd1, 12'hFFF, 8'h00, 1'b0, 16'd0, 1'b0);
        run_voice(2'd2, 12'hFFF, 8'h00, 1'b1, 16'd16312, 1'b0);
        repeat (15) @(negedge clk_i);

        // -2048*128 = -262144, >>>5 = -8192.
        run_voice(2'd0, 12'h000, 8'h80, 1'b0, 16'd0, 1'b0);
        run_voice(2'd1, 12'h800, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd2, 12'h800, 8'hFF, 1'b1, 16'hE000, 1'b0);

        // Out-of-range voice index leaves accumulator and mix untouched.
        run_voice(2'd0, 12'hFFF, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd1, 12'hFFF, 8'h00, 1'b0, 16'd0, 1'b0);
        run_voice(2'd3, 12'hFFF, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd2, 12'hFFF, 8'h00, 1'b1, 16'd16312, 1'b0);

        // Saturation both ways.
        run_voice(2'd0, 12'hFFF, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd1, 12'hFFF, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd2, 12'hFFF, 8'hFF, 1'b1, 16'h7FFF, 1'b0);
        run_voice(2'd0, 12'h000, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd1, 12'h000, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd2, 12'h000, 8'hFF, 1'b1, 16'h8000, 1'b0);

        // Reset during MULT abandons the voice without a ready_o pulse.
        start_i     = 1'b1;
        voice_idx_i = 2'd2;
        wave_i      = 12'hFFF;
        env_i       = 8'hFF;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_mix_held = '0;
        check("post_reset_busy", int'(busy_o), 0);
        check("post_reset_mix", int'(mix_o), 0);
        check("post_reset_ready", int'(ready_o), 0);
        check("post_reset_mix_valid", int'(mix_valid_o), 0);
        repeat (12) @(negedge clk_i);
        run_voice(2'd0, 12'hFFF, 8'hFF, 1'b0, 16'd0, 1'b0);
        run_voice(2'd1, 12'hFFF, 8'h00, 1'b0, 16'd0, 1'b0);
        run_voice(2'd2, 12'hFFF, 8'h00, 1'b1, 16'd16312, 1'b0);

        repeat (3) @(negedge clk_i);
        check("pending_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
        $finish;
    end

endmodule
